codec_write_buffer: RTL and testbench

//  Elastic stereo buffer between the filter/noise write path and the audio_codec write port.

---
 rtl/codec_buf_pkg.sv | 15 +
 rtl/stereo_fifo_mem.sv | 49 ++++
 rtl/codec_write_buffer.sv | 145 ++++++++++++++
 tb/tb_codec_write_buffer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/codec_buf_pkg.sv
// rtl/codec_buf_pkg.sv - shared types and constants for the codec write buffer
// Purpose : buffer state encoding, stereo pair layout and the default sample width.
// Contents: DATA_W_DEFAULT, buf_state_t (FILL/RUN), stereo_t (24-bit left/right pair).
package codec_buf_pkg;

  localparam int DATA_W_DEFAULT = 24;

  typedef enum logic {FILL, RUN} buf_state_t;

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
  } stereo_t;

endpackage

// File: rtl/stereo_fifo_mem.sv
// rtl/stereo_fifo_mem.sv - DEPTH x stereo-pair register array with wrapping pointers
// Purpose : storage for the codec write buffer; synchronous write, asynchronous read.
// Ports   : clk, rst_n         clock, asynchronous active-low reset (pointers only)
//           push, wdata_l/r    write the pair at the write pointer and advance it
//           pop                advance the read pointer
//           rdata_l/r          pair at the read pointer (combinational)
module stereo_fifo_mem #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata_l,
  input  logic [DATA_W-1:0] wdata_r,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata_l,
  output logic [DATA_W-1:0] rdata_r
);

  logic [2*DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Array contents need no reset: the level counter guards every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {wdata_l, wdata_r};
  end

  assign {rdata_l, rdata_r} = mem_q[rd_ptr_q];

endmodule

// File: rtl/codec_write_buffer.sv
// rtl/codec_write_buffer.sv - elastic stereo buffer feeding the audio codec write port
// Purpose : accepts pairs on in_valid/in_ready, prefills to DEPTH/2, then drains one
//           pair per codec write_ready; repeats the last pair on underrun.
// Ports   : CLOCK_50, reset_n                 clock, asynchronous active-low reset
//           in_valid, in_left/right, in_ready upstream handshake
//           write_ready, write, writedata_*   codec write port
//           level                             occupied entries 0..DEPTH
//           underrun, overflow                single-cycle event pulses
// Option  : CODEC_WRITE_BUFFER_STATS_EN adds saturating underrun_cnt / overflow_cnt.
module codec_write_buffer
  import codec_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  output logic              in_ready,
  input  logic              write_ready,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic [ADDR_W:0]   level,
  output logic              underrun,
  output logic              overflow
`ifdef CODEC_WRITE_BUFFER_STATS_EN
  ,
  output logic [15:0]       underrun_cnt,
  output logic [15:0]       overflow_cnt
`endif
);

  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_HALF = (ADDR_W+1)'(DEPTH / 2);
  localparam logic [ADDR_W:0] LVL_ONE  = (ADDR_W+1)'(1);

  buf_state_t        state_q, state_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] last_l_q, last_l_d;
  logic [DATA_W-1:0] last_r_q, last_r_d;
  logic [DATA_W-1:0] head_l, head_r;

  logic full, empty, push, serve, pop, underrun_c, overflow_c;

  assign full       = (level_q == LVL_FULL);
  assign empty      = (level_q == '0);
  assign push       = in_valid & in_ready_q;
  assign serve      = (state_q == RUN) & write_ready;
  assign pop        = serve & ~empty;
  assign underrun_c = serve & empty;
  assign overflow_c = in_valid & full;

  stereo_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (CLOCK_50),
    .rst_n   (reset_n),
    .push    (push),
    .wdata_l (in_left),
    .wdata_r (in_right),
    .pop     (pop),
    .rdata_l (head_l),
    .rdata_r (head_r)
  );

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    state_d = state_q;
    unique case (state_q)
      FILL: if (level_q >= LVL_HALF) state_d = RUN;
      RUN:  if (underrun_c)          state_d = FILL;
      default:                       state_d = FILL;
    endcase

    last_l_d = pop ? head_l : last_l_q;
    last_r_d = pop ? head_r : last_r_q;

    // Registered ready tracks the next level; it reads 0 while in reset.
    in_ready_d = (level_d != LVL_FULL);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FILL;
      level_q    <= '0;
      in_ready_q <= 1'b0;
      last_l_q   <= '0;
      last_r_q   <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      in_ready_q <= in_ready_d;
      last_l_q   <= last_l_d;
      last_r_q   <= last_r_d;
    end
  end

  // Head is shown only while running with data; otherwise the held pair repeats.
  assign write           = serve;
  assign writedata_left  = ((state_q == RUN) && !empty) ? head_l : last_l_q;
  assign writedata_right = ((state_q == RUN) && !empty) ? head_r : last_r_q;
  assign in_ready        = in_ready_q;
  assign level           = level_q;
  assign underrun        = underrun_c;
  assign overflow        = overflow_c;

`ifdef CODEC_WRITE_BUFFER_STATS_EN
  logic [15:0] underrun_cnt_q, underrun_cnt_d;
  logic [15:0] overflow_cnt_q, overflow_cnt_d;

  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    overflow_cnt_d = overflow_cnt_q;
    if (underrun_c && (underrun_cnt_q != 16'hFFFF)) underrun_cnt_d = underrun_cnt_q + 16'd1;
    if (overflow_c && (overflow_cnt_q != 16'hFFFF)) overflow_cnt_d = overflow_cnt_q + 16'd1;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      underrun_cnt_q <= '0;
      overflow_cnt_q <= '0;
    end else begin
      underrun_cnt_q <= underrun_cnt_d;
      overflow_cnt_q <= overflow_cnt_d;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
  assign overflow_cnt = overflow_cnt_q;
`endif

endmodule

// File: tb/tb_codec_write_buffer.sv
// tb/tb_codec_write_buffer.sv - self-checking bench for codec_write_buffer (DEPTH=8)
module tb_codec_write_buffer;
  import codec_buf_pkg::*;

  localparam int DW = 24;

  logic          CLOCK_50 = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic [DW-1:0] in_left, in_right;
  logic          in_ready;
  logic          write_ready;
  logic          write;
  logic [DW-1:0] writedata_left, writedata_right;
  logic [3:0]    level;
  logic          underrun, overflow;
`ifdef CODEC_WRITE_BUFFER_STATS_EN
  logic [15:0]   underrun_cnt, overflow_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  codec_write_buffer #(.DATA_W(DW), .DEPTH(8)) dut (
    .CLOCK_50        (CLOCK_50),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_left         (in_left),
    .in_right        (in_right),
    .in_ready        (in_ready),
    .write_ready     (write_ready),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .level           (level),
    .underrun        (underrun),
    .overflow        (overflow)
`ifdef CODEC_WRITE_BUFFER_STATS_EN
    ,
    .underrun_cnt    (underrun_cnt),
    .overflow_cnt    (overflow_cnt)
`endif
  );

  typedef struct {
    logic          v;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic          wr;
    logic          e_write;
    logic [DW-1:0] e_wl;
    logic [DW-1:0] e_wr;
    logic [3:0]    e_level;
    logic          e_ready;
    logic          e_und;
    logic          e_ov;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic v, input logic [DW-1:0] l, input logic [DW-1:0] r,
                              input logic wr, input logic e_write, input logic [DW-1:0] e_wl,
                              input logic [DW-1:0] e_wr, input logic [3:0] e_level,
                              input logic e_ready, input logic e_und, input logic e_ov);
    vec_t t;
    t.v = v; t.l = l; t.r = r; t.wr = wr;
    t.e_write = e_write; t.e_wl = e_wl; t.e_wr = e_wr; t.e_level = e_level;
    t.e_ready = e_ready; t.e_und = e_und; t.e_ov = e_ov;
    return t;
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] l, input logic [DW-1:0] r,
                       input logic wr);
    in_valid = v; in_left = l; in_right = r; write_ready = wr;
  endtask

  initial begin
    //                 v     left      right       wr    write  wd_left    wd_right     lvl   rdy   und   ov
    tbl[0]  = mk(1'b1, 24'h1, 24'hFFFFFF, 1'b1, 1'b0, 24'h0, 24'h0,      4'd0, 1'b1, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 24'h2, 24'hFFFFFE, 1'b1, 1'b0, 24'h0, 24'h0,      4'd1, 1'b1, 1'b0, 1'b0);
    tbl[2]  = mk(1'b1, 24'h3, 24'hFFFFFD, 1'b1, 1'b0, 24'h0, 24'h0,      4'd2, 1'b1, 1'b0, 1'b0);
    tbl[3]  = mk(1'b1, 24'h4, 24'hFFFFFC, 1'b1, 1'b0, 24'h0, 24'h0,      4'd3, 1'b1, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 24'h0, 24'h0,      1'b1, 1'b0, 24'h0, 24'h0,      4'd4, 1'b1, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 24'h0, 24'h0,      1'b1, 1'b1, 24'h1, 24'hFFFFFF, 4'd4, 1'b1, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 24'h5, 24'hFFFFFB, 1'b1, 1'b1, 24'h2, 24'hFFFFFE, 4'd3, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 24'h0, 24'h0,      1'b0, 1'b0, 24'h3, 24'hFFFFFD, 4'd3, 1'b1, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 24'h0, 24'h0,      1'b1, 1'b1, 24'h3, 24'hFFFFFD, 4'd3, 1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 24'h0, 24'h0,      1'b1, 1'b1, 24'h4, 24'hFFFFFC, 4'd2, 1'b1, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 24'h6, 24'hFFFFFA, 1'b1, 1'b1, 24'h5, 24'hFFFFFB, 4'd1, 1'b1, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 24'h0, 24'h0,      1'b1, 1'b1, 24'h6, 24'hFFFFFA, 4'd1, 1'b1, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 24'h0, 24'h0,      1'b1, 1'b1, 24'h6, 24'hFFFFFA, 4'd0, 1'b1, 1'b1, 1'b0);
    tbl[13] = mk(1'b0, 24'h0, 24'h0,      1'b1, 1'b0, 24'h6, 24'hFFFFFA, 4'd0, 1'b1, 1'b0, 1'b0);

    reset_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("reset_level", 48'(level), 48'd0);
    check("reset_write", 48'(write), 48'd0);
    check("reset_wdata", {writedata_left, writedata_right}, 48'd0);
    reset_n = 1'b1;
    tick();

    // Prefill, run, concurrent push/pop at level 1 and underrun.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].wr);
      #2;
      check($sformatf("v%0d_write", i),    48'(write),           48'(tbl[i].e_write));
      check($sformatf("v%0d_wd_left", i),  48'(writedata_left),  48'(tbl[i].e_wl));
      check($sformatf("v%0d_wd_right", i), 48'(writedata_right), 48'(tbl[i].e_wr));
      check($sformatf("v%0d_level", i),    48'(level),           48'(tbl[i].e_level));
      check($sformatf("v%0d_in_ready", i), 48'(in_ready),        48'(tbl[i].e_ready));
      check($sformatf("v%0d_underrun", i), 48'(underrun),        48'(tbl[i].e_und));
      check($sformatf("v%0d_overflow", i), 48'(overflow),        48'(tbl[i].e_ov));
      tick();
    end

    // Fill to full with the codec stalled; the ninth pair must be dropped.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 24'h100 + 24'(k), 24'h200 + 24'(k), 1'b0);
      tick();
    end
    drive(1'b1, 24'hBADBAD, 24'hBADBAD, 1'b0);
    #2;
    check("full_level", 48'(level), 48'd8);
    check("full_in_ready", 48'(in_ready), 48'd0);
    check("full_overflow", 48'(overflow), 48'd1);
    check("full_write", 48'(write), 48'd0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    #2;
    check("ovf_pulse_end", 48'(overflow), 48'd0);
    check("ovf_level_kept", 48'(level), 48'd8);
    tick();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, '0, '0, 1'b1);
      #2;
      check($sformatf("drain%0d_write", k), 48'(write), 48'd1);
      check($sformatf("drain%0d_data", k), {writedata_left, writedata_right},
            {24'h100 + 24'(k), 24'h200 + 24'(k)});
      tick();
    end
    #2;
    check("drain_underrun", 48'(underrun), 48'd1);
    check("drain_repeat", {writedata_left, writedata_right}, {24'h107, 24'h207});
    tick();
    #2;
    check("after_underrun_write", 48'(write), 48'd0);

    // Asynchronous reset in the middle of a running stream.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 24'h300 + 24'(k), 24'h400 + 24'(k), 1'b0);
      tick();
    end
    drive(1'b1, 24'h3FF, 24'h4FF, 1'b1);
    #2;
    check("pre_reset_write", 48'(write), 48'd1);
    check("pre_reset_level", 48'(level), 48'd5);
    reset_n = 1'b0;
    #1;
    check("async_reset_level", 48'(level), 48'd0);
    check("async_reset_write", 48'(write), 48'd0);
    check("async_reset_wdata", {writedata_left, writedata_right}, 48'd0);
    check("async_reset_in_ready", 48'(in_ready), 48'd0);
    check("async_reset_underrun", 48'(underrun), 48'd0);
`ifdef CODEC_WRITE_BUFFER_STATS_EN
    check("async_reset_cnts", {16'd0, underrun_cnt, overflow_cnt}, 48'd0);
`endif
    #1;
    reset_n = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    check("post_reset_level", 48'(level), 48'd0);

`ifdef CODEC_WRITE_BUFFER_STATS_EN
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 24'h500 + 24'(k), 24'h600 + 24'(k), 1'b1);
      tick();
    end
    drive(1'b0, '0, '0, 1'b1);
    repeat (6) tick();
    check("stats_underrun_cnt", 48'(underrun_cnt), 48'd1);
    drive(1'b1, 24'h777, 24'h777, 1'b0);
    repeat (70010) tick();
    check("stats_overflow_sat", 48'(overflow_cnt), 48'hFFFF);
    check("stats_underrun_kept", 48'(underrun_cnt), 48'd1);
    drive(1'b0, '0, '0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
